// File: rtl/fire_expand3_ofm_writer.sv
//------------------------------------------------------------------------------
// Module   : fire_expand3_ofm_writer
// Purpose  : Captures expand-3x3 channel results per output pixel and serialises
//            them into the concatenated fire OFM RAM; optional running checksum
//            of written words when FIRE_OFM_WR_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fire_expand3_ofm_writer #(
  parameter int WIDTH    = 16,
  parameter int CH       = 128,
  parameter int CH_TOTAL = 256,
  parameter int CH_BASE  = 128,
  parameter int WOUT     = 32,
  parameter int ADDR_W   = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_start_i,
  input  logic              sample_i,
  input  logic [WIDTH-1:0]  ofm_i [CH],
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WIDTH-1:0]  wr_data_o,
  output logic              busy_o,
  output logic              ram_feedback_o,
  output logic              layer_done_o,
  output logic              overrun_o
`ifdef FIRE_OFM_WR_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o
`endif
);

  localparam int CH_W  = $clog2(CH);
  localparam int PIX_W = $clog2(WOUT * WOUT) + 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(WOUT * WOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  shadow [CH];
  logic [CH_W-1:0]   ch_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic              ch_last;
  logic              pix_last;
  logic              capture;
  logic [ADDR_W-1:0] addr_next;

  assign ch_last  = (ch_cnt == CH_LAST);
  assign pix_last = (pix_cnt == PIX_LAST);
  assign busy_o   = (state == DRAIN);

  // Modular ADDR_W arithmetic yields the same low bits as a full-width sum.
  assign addr_next = ADDR_W'(pix_cnt) * ADDR_W'(CH_TOTAL) + ADDR_W'(CH_BASE) + ADDR_W'(ch_cnt);

  // Recapture only in IDLE or on the final word of a non-final pixel.
  assign capture = !rst && !layer_start_i && sample_i &&
                   ((state == IDLE) || (state == DRAIN && ch_last && !pix_last));

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int c = 0; c < CH; c++) begin
        shadow[c] <= ofm_i[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ch_cnt         <= '0;
      pix_cnt        <= '0;
      wr_en_o        <= 1'b0;
      wr_addr_o      <= '0;
      wr_data_o      <= '0;
      ram_feedback_o <= 1'b0;
      layer_done_o   <= 1'b0;
      overrun_o      <= 1'b0;
    end else if (layer_start_i) begin
      state          <= IDLE;
      ch_cnt         <= '0;
      pix_cnt        <= '0;
      wr_en_o        <= 1'b0;
      ram_feedback_o <= 1'b0;
      layer_done_o   <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      wr_en_o        <= 1'b0;
      ram_feedback_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_i) begin
            ch_cnt <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          wr_en_o   <= 1'b1;
          wr_data_o <= shadow[ch_cnt];
          wr_addr_o <= addr_next;
          ch_cnt    <= ch_cnt + 1'b1;
          if (ch_last) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_last) begin
              state <= DONE;
            end else if (sample_i) begin
              ch_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (sample_i) begin
            overrun_o <= 1'b1;
          end
        end
        DONE: begin
          // layer_done_o doubles as the "feedback already pulsed" flag.
          ram_feedback_o <= !layer_done_o;
          layer_done_o   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIRE_OFM_WR_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || layer_start_i) begin
      checksum_o <= '0;
    end else if (state == DRAIN) begin
      checksum_o <= checksum_o + 32'(shadow[ch_cnt]);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fire_expand3_ofm_writer.sv
// Scoreboard bench for fire_expand3_ofm_writer (WOUT reduced to keep the full-layer run short).
`default_nettype none

module tb_fire_expand3_ofm_writer;

  localparam int WIDTH    = 16;
  localparam int CH       = 128;
  localparam int CH_TOTAL = 256;
  localparam int CH_BASE  = 128;
  localparam int WOUT     = 8;
  localparam int ADDR_W   = 14;
  localparam int NPIX     = WOUT * WOUT;

  logic              clk = 1'b0;
  logic              rst;
  logic              layer_start_i;
  logic              sample_i;
  logic [WIDTH-1:0]  ofm [CH];
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [WIDTH-1:0]  wr_data_o;
  logic              busy_o;
  logic              ram_feedback_o;
  logic              layer_done_o;
  logic              overrun_o;
`ifdef FIRE_OFM_WR_CHECKSUM_EN
  logic [31:0]       checksum_o;
`endif

  always #5 clk = ~clk;

  fire_expand3_ofm_writer #(
    .WIDTH(WIDTH), .CH(CH), .CH_TOTAL(CH_TOTAL), .CH_BASE(CH_BASE),
    .WOUT(WOUT), .ADDR_W(ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .layer_start_i  (layer_start_i),
    .sample_i       (sample_i),
    .ofm_i          (ofm),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .busy_o         (busy_o),
    .ram_feedback_o (ram_feedback_o),
    .layer_done_o   (layer_done_o),
    .overrun_o      (overrun_o)
`ifdef FIRE_OFM_WR_CHECKSUM_EN
    ,
    .checksum_o     (checksum_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0, nwr = 0, nbusy = 0, nfb = 0;
  int fb_cyc = -1, first_cyc = -1, last_cyc = -1;
  logic [31:0] last_addr = '0;
  logic [31:0] exp_addr [$];
  logic [15:0] exp_data [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every presented write.
  always @(negedge clk) begin
    cyc++;
    if (wr_en_o === 1'b1) begin
      nwr++;
      last_addr = 32'(wr_addr_o);
      last_cyc  = cyc;
      if (first_cyc < 0) first_cyc = cyc;
      if (exp_addr.size() == 0) begin
        check("unexpected_write", 32'(wr_addr_o), 32'hFFFF_FFFF);
      end else begin
        check("wr_addr", 32'(wr_addr_o), exp_addr.pop_front());
        check("wr_data", 32'(wr_data_o), 32'(exp_data.pop_front()));
      end
    end
    if (busy_o === 1'b1) nbusy++;
    if (ram_feedback_o === 1'b1) begin
      nfb++;
      fb_cyc = cyc;
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_sample(input int pix, input bit pat_inc);
    for (int c = 0; c < CH; c++) begin
      ofm[c] = pat_inc ? 16'(c + 1) : (16'(pix) ^ 16'(c));
      exp_addr.push_back(32'((pix * CH_TOTAL + CH_BASE + c) % (1 << ADDR_W)));
      exp_data.push_back(ofm[c]);
    end
    sample_i = 1'b1;
    tick();
    sample_i = 1'b0;
  endtask

  task automatic inject_overrun();
    for (int c = 0; c < CH; c++) ofm[c] = 16'hDEAD ^ 16'(c);
    sample_i = 1'b1;
    tick();
    sample_i = 1'b0;
  endtask

  task automatic pulse_layer_start();
    layer_start_i = 1'b1;
    tick();
    layer_start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    layer_start_i = 1'b0;
    sample_i = 1'b0;
    for (int c = 0; c < CH; c++) ofm[c] = '0;
    repeat (3) tick();
    check("rst_wr_en", 32'(wr_en_o), 0);
    check("rst_wr_addr", 32'(wr_addr_o), 0);
    check("rst_wr_data", 32'(wr_data_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_feedback", 32'(ram_feedback_o), 0);
    check("rst_done", 32'(layer_done_o), 0);
    check("rst_overrun", 32'(overrun_o), 0);
    rst = 1'b0;
    nwr = 0;
    repeat (50) tick();
    check("idle_writes", 32'(nwr), 0);

    // Single pixel, data c+1
    pulse_layer_start();
    nbusy = 0; nwr = 0; nfb = 0;
    do_sample(0, 1'b1);
    @(negedge clk);
    check("latency_early", 32'(wr_en_o), 0);
    @(negedge clk);
    check("first_wr_en", 32'(wr_en_o), 1);
    check("first_addr", 32'(wr_addr_o), 128);
    repeat (200) tick();
    check("single_busy", 32'(nbusy), 128);
    check("single_writes", 32'(nwr), 128);
    check("single_idle", 32'(busy_o), 0);
    check("single_no_fb", 32'(nfb), 0);
    check("single_sb_empty", 32'(exp_addr.size()), 0);
`ifdef FIRE_OFM_WR_CHECKSUM_EN
    check("checksum_pixel", checksum_o, 8256);
`endif

    // Back-to-back at a 128-cycle sample period
    nwr = 0; first_cyc = -1;
    do_sample(1, 1'b0);
    repeat (CH - 1) tick();
    do_sample(2, 1'b0);
    repeat (CH - 1) tick();
    do_sample(3, 1'b0);
    repeat (140) tick();
    check("b2b_writes", 32'(nwr), 384);
    check("b2b_no_bubble", 32'(last_cyc - first_cyc + 1), 384);
    check("b2b_overrun", 32'(overrun_o), 0);
    check("b2b_sb_empty", 32'(exp_addr.size()), 0);

    // Overrun at ch_cnt=5: drain continues with the original data
    do_sample(4, 1'b0);
    repeat (5) tick();
    check("ovr_pre", 32'(overrun_o), 0);
    inject_overrun();
    check("ovr_set", 32'(overrun_o), 1);
    repeat (140) tick();
    check("ovr_sticky", 32'(overrun_o), 1);
    check("ovr_sb_empty", 32'(exp_addr.size()), 0);

    // Reset at ch_cnt=60 aborts the drain
    do_sample(5, 1'b0);
    repeat (60) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("abort_wr_en", 32'(wr_en_o), 0);
    check("abort_pending", 32'(exp_addr.size()), 68);
    exp_addr.delete();
    exp_data.delete();
    tick();
    rst = 1'b0;
    check("abort_overrun_clr", 32'(overrun_o), 0);
    nwr = 0;
    repeat (20) tick();
    check("abort_no_writes", 32'(nwr), 0);

    // Full layer at the nominal 289-cycle period
    pulse_layer_start();
    nwr = 0; nfb = 0; fb_cyc = -1;
    for (int p = 0; p < NPIX; p++) begin
      do_sample(p, 1'b0);
      repeat (288) tick();
    end
    check("layer_writes", 32'(nwr), 32'(NPIX * CH));
    check("layer_last_addr", last_addr, 32'((NPIX - 1) * CH_TOTAL + CH_TOTAL - 1));
    check("layer_fb_count", 32'(nfb), 1);
    check("layer_fb_timing", 32'(fb_cyc), 32'(last_cyc + 1));
    check("layer_done", 32'(layer_done_o), 1);
    check("layer_overrun", 32'(overrun_o), 0);
    check("layer_sb_empty", 32'(exp_addr.size()), 0);
    sample_i = 1'b1;
    tick();
    sample_i = 1'b0;
    repeat (5) tick();
    check("done_ignore_ovr", 32'(overrun_o), 0);
    check("done_ignore_wr", 32'(nwr), 32'(NPIX * CH));
    check("done_hold", 32'(layer_done_o), 1);

    // Rearm, then an overrun to be cleared by the next rearm
    pulse_layer_start();
    check("rearm_done_clr", 32'(layer_done_o), 0);
`ifdef FIRE_OFM_WR_CHECKSUM_EN
    check("rearm_checksum_clr", checksum_o, 0);
`endif
    do_sample(0, 1'b0);
    repeat (5) tick();
    inject_overrun();
    check("ovr2_set", 32'(overrun_o), 1);
    repeat (140) tick();
    check("ovr2_sb_empty", 32'(exp_addr.size()), 0);

    pulse_layer_start();
    check("rearm_ovr_clr", 32'(overrun_o), 0);
    do_sample(0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("restart_addr", 32'(wr_addr_o), 128);
    repeat (140) tick();
    check("restart_sb_empty", 32'(exp_addr.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fire_expand3_ofm_writer.md
Name: fire_expand3_ofm_writer

Overview:
- Downstream stage of the fire4/fire5 expand-3x3 core.
- On each output-sample pulse it captures the 128 parallel 16-bit channel results into a shadow buffer, then serialises them into the concatenated fire output feature-map RAM, one word per cycle.
- The expand-3x3 channels occupy the upper half of each 256-channel pixel; the expand-1x1 channels occupy the lower half.
- After the last pixel it pulses the RAM-feedback handshake back to the expand core.

Parameters:
- WIDTH, 16, data word width.
- CH, 128, channels captured per sample (expand-3x3 output depth).
- CH_TOTAL, 256, channels per pixel in the concatenated output RAM.
- CH_BASE, 128, channel offset of this block's channels inside a pixel.
- WOUT, 32, output feature-map width/height; pixels per layer = WOUT*WOUT = 1024.
- ADDR_W, 18, RAM address width = clog2(CH_TOTAL*WOUT*WOUT).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- layer_start_i  in  1  one-cycle pulse: rearm for a new layer (fire4 or fire5).
- sample_i  in  1  one-cycle pulse: ofm_i is valid this cycle.
- ofm_i  in  CH x WIDTH  unpacked array of channel results from the expand core.
- wr_en_o  out  1  RAM write enable, registered.
- wr_addr_o  out  ADDR_W  RAM write address, registered.
- wr_data_o  out  WIDTH  RAM write data, registered.
- busy_o  out  1  high while the writer is in DRAIN.
- ram_feedback_o  out  1  one-cycle pulse after the last word of the layer is written.
- layer_done_o  out  1  level; high from the feedback pulse until layer_start_i or rst.
- overrun_o  out  1  sticky; a sample arrived that could not be accepted.

Behaviour:
- Reset: every output is 0; state = IDLE; pixel counter, channel counter, done and overrun are cleared. rst mid-drain aborts the drain immediately and no further writes occur.
- Counters:
  - ch_cnt: clog2(CH) bits.
  - pix_cnt: clog2(WOUT*WOUT)+1 bits.
- State machine, IDLE / DRAIN / DONE:
  - IDLE, sample_i=1: capture all ofm_i into buf, ch_cnt=0, go to DRAIN.
  - DRAIN, every cycle:
    - wr_en_o=1.
    - wr_data_o=buf[ch_cnt].
    - wr_addr_o = pix_cnt*CH_TOTAL + CH_BASE + ch_cnt, computed at full width and truncated to ADDR_W.
    - ch_cnt increments.
  - DRAIN, ch_cnt==CH-1:
    - pix_cnt increments.
    - If pix_cnt was WOUT*WOUT-1, go to DONE.
    - Else if sample_i=1 in this cycle, recapture buf, ch_cnt=0 and stay in DRAIN (back-to-back, no bubble).
    - Else go to IDLE.
  - DONE, first cycle: ram_feedback_o=1 for exactly one cycle, layer_done_o=1; then remain in DONE. sample_i is ignored in DONE (not an overrun).
- Latency: sample_i at edge k gives the first write visible after edge k+1; CH consecutive write cycles follow. The feedback pulse is visible the cycle after the last write.
- Overrun: sample_i in DRAIN when ch_cnt != CH-1 sets overrun_o (sticky). The sample is dropped, and buf and the in-progress drain are unaffected.
- layer_start_i:
  - Effect: clears pix_cnt, ch_cnt, layer_done_o and overrun_o, and forces IDLE; wr_en_o=0 next cycle.
  - Priority: below rst, above sample_i in the same cycle (that sample is dropped, no overrun).
- wr_en_o is 0 in IDLE and DONE. wr_addr_o and wr_data_o hold their last values when not writing.
- Input rate: the expand core delivers a sample every 289 cycles, leaving 161 idle cycles per pixel. The back-to-back path guarantees correctness down to a CH-cycle sample period.

Optional Feature:
- Macro: FIRE_OFM_WR_CHECKSUM_EN.
- Defined: adds output port checksum_o (32 bits).
  - Cleared by rst and layer_start_i.
  - Each cycle with wr_en_o=1, checksum_o += zero-extended wr_data_o, wrapping modulo 2^32.
  - Updated in the same cycle as the write is presented.
  - Holds its value in DONE for comparison against the golden model.
- Not defined: port and adder absent; all other behaviour identical.

Test Plan:
- Reset/idle: rst 3 cycles, no sample → all outputs 0; wr_en_o stays 0 for 50 cycles.
- Single pixel: layer_start_i, then sample_i with ofm_i[c]=c+1 → 128 consecutive writes, addr 128..255, data 1..128. busy_o high exactly 128 cycles, then IDLE. No feedback.
- Full layer: 1024 samples spaced 289 cycles, ofm_i[c]=pixel[15:0]^c:
  - Last write addr = 1023*256+255 = 262143.
  - ram_feedback_o one-cycle pulse exactly 1 cycle after that write; layer_done_o stays 1.
  - Exactly 131072 writes; overrun_o=0.
- Back-to-back and overrun:
  - Sample period exactly 128 → no bubble between pixels, overrun_o=0.
  - A sample issued at ch_cnt=5 → overrun_o=1 and the current pixel's data is unchanged.
- Rearm/reset mid-operation:
  - rst at ch_cnt=60 → wr_en_o=0 next cycle.
  - layer_start_i then sample → writes restart at addr 128; layer_done_o and overrun_o cleared.
- Checksum (FIRE_OFM_WR_CHECKSUM_EN defined): single pixel with ofm_i[c]=c+1 → checksum_o=8256 after the drain. Layer rearm clears it to 0.
